// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared definitions for the FIFO read-side drain controller: state encoding and width defaults.
package fifo_drain_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    // Occupancy-coded states; ST_FLUSH is reachable only when the flush feature is built in.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_drain_ctrl_skid_buf_2.sv
// Two-entry skid buffer: register file with independent write/read pointers.
module fifo_drain_ctrl_skid_buf_2
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] entry_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;

    // Entry storage and pointer advance; a freed slot may be refilled on the same edge it is read out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q[0] <= {DATA_W{1'b0}};
            entry_q[1] <= {DATA_W{1'b0}};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else if (clr) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= wr_data;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign rd_data = entry_q[rd_ptr_q];

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the shared-port 32x8 FIFO, presenting bytes on a valid/ready stream.
// Optional feature: define FIFO_DRAIN_FLUSH_EN to add the Flush port and FLUSH state.
module fifo_drain_ctrl
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Fifo_Data,
    input  logic              Fifo_Empty,
    input  logic              Wr_Pending,
    output logic              Fifo_Pop,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
`ifdef FIFO_DRAIN_FLUSH_EN
    input  logic              Flush,
`endif
    output logic [CNT_W-1:0]  Pop_Count
);

    state_e            state_q;
    state_e            state_d;
    logic              flush_s;
    logic              space_s;
    logic              deq_s;
    logic              pop_s;
    logic              push_s;
    logic              clr_s;
    logic [CNT_W-1:0]  cnt_q;

`ifdef FIFO_DRAIN_FLUSH_EN
    assign flush_s = Flush;
`else
    assign flush_s = 1'b0;
`endif

    assign Out_Valid = (state_q == ST_ONE) || (state_q == ST_TWO);
    assign deq_s     = Out_Valid & Out_Ready;
    assign space_s   = (state_q != ST_TWO) | Out_Ready;

    // State register.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pop decision; a FLUSH state with Flush low behaves exactly like EMPTY.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        clr_s   = 1'b0;
        if (flush_s) begin
            pop_s   = ~Fifo_Empty & ~Wr_Pending;
            clr_s   = 1'b1;
            state_d = ST_FLUSH;
        end else begin
            pop_s = ~Fifo_Empty & ~Wr_Pending & space_s;
            case (state_q)
                ST_EMPTY, ST_FLUSH: begin
                    if (pop_s) begin
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (pop_s & ~deq_s) begin
                        state_d = ST_TWO;
                    end else if (deq_s & ~pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (deq_s & ~pop_s) begin
                        state_d = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    assign Fifo_Pop = Reset & pop_s;
    assign push_s   = pop_s & ~flush_s;

    fifo_drain_ctrl_skid_buf_2 #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (CLK),
        .rst_n   (Reset),
        .clr     (clr_s),
        .push    (push_s),
        .wr_data (Fifo_Data),
        .pop     (deq_s),
        .rd_data (Out_Data)
    );

    // Pop statistics counter; wraps naturally, flushed pops included.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (Fifo_Pop) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign Pop_Count = cnt_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl: queue-based FIFO and stream model, randomized traffic.
module tb_fifo_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        wr_pending;
    logic        fifo_pop;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        flush_s;
    logic [15:0] pop_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] fq[$];
    logic [7:0] sq[$];
    int         cnt_m;

    always #5 clk = ~clk;

    fifo_drain_ctrl dut (
        .CLK        (clk),
        .Reset      (rst_n),
        .Fifo_Data  (fifo_data),
        .Fifo_Empty (fifo_empty),
        .Wr_Pending (wr_pending),
        .Fifo_Pop   (fifo_pop),
        .Out_Data   (out_data),
        .Out_Valid  (out_valid),
        .Out_Ready  (out_ready),
`ifdef FIFO_DRAIN_FLUSH_EN
        .Flush      (flush_s),
`endif
        .Pop_Count  (pop_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: present FIFO head, compare outputs with the model, then advance the model.
    task automatic cycle();
        logic e_pop;
        logic e_valid;
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() > 0) ? fq[0] : 8'h00;
        #1;
        e_valid = (sq.size() > 0);
        if (flush_s)
            e_pop = !fifo_empty && !wr_pending;
        else
            e_pop = !fifo_empty && !wr_pending && (sq.size() < 2 || out_ready);
        chk("fifo_pop", fifo_pop, e_pop);
        chk("out_valid", out_valid, e_valid);
        if (e_valid) chk("out_data", out_data, sq[0]);
        chk("pop_count", pop_count, cnt_m % 65536);
        if (wr_pending) chk("pop_during_wr_pending", fifo_pop, 1'b0);
        @(posedge clk);
        if (flush_s) begin
            sq.delete();
            if (e_pop) void'(fq.pop_front());
        end else begin
            if (e_valid && out_ready) void'(sq.pop_front());
            if (e_pop) sq.push_back(fq.pop_front());
        end
        if (e_pop) cnt_m = (cnt_m + 1) % 65536;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        sq.delete();
        fq.delete();
        cnt_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        wr_pending = 1'b0;
        flush_s    = 1'b0;
        fifo_data  = 8'h00;
        fifo_empty = 1'b1;
        cnt_m      = 0;
        #2;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_data", out_data, 8'h00);
        chk("reset_count", pop_count, 16'h0000);
        chk("reset_pop", fifo_pop, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Three preloaded bytes stream out back to back.
        out_ready = 1'b1;
        fq = '{8'h11, 8'h22, 8'h33};
        cycle();
        chk("t1_b0_valid", out_valid, 1'b1);
        chk("t1_b0", out_data, 8'h11);
        cycle();
        chk("t1_b1", out_data, 8'h22);
        cycle();
        chk("t1_b2", out_data, 8'h33);
        cycle();
        chk("t1_idle", out_valid, 1'b0);
        chk("t1_count", pop_count, 16'd3);

        // Backpressure: only two pops absorbed, head byte held.
        out_ready = 1'b0;
        fq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        for (int i = 0; i < 4; i++) cycle();
        chk("t2_count_held", pop_count, 16'd5);
        chk("t2_head", out_data, 8'hA1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("t2_count_done", pop_count, 16'd8);
        chk("t2_idle", out_valid, 1'b0);

        // Write side owns the port every other cycle.
        fq = '{8'h5C, 8'h6D, 8'h7E, 8'h8F};
        for (int i = 0; i < 12; i++) begin
            wr_pending = i[0];
            cycle();
        end
        wr_pending = 1'b0;
        chk("t3_count", pop_count, 16'd12);
        chk("t3_idle", out_valid, 1'b0);

        // Asynchronous reset with two bytes buffered.
        out_ready = 1'b0;
        fq = '{8'hC1, 8'hC2, 8'hC3};
        for (int i = 0; i < 3; i++) cycle();
        chk("t4_pre_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_valid", out_valid, 1'b0);
        chk("t4_count", pop_count, 16'd0);
        chk("t4_pop", fifo_pop, 1'b0);
        sq.delete();
        fq.delete();
        cnt_m = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            out_ready  = ($urandom_range(0, 3) != 0);
            wr_pending = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1 && fq.size() < 32) fq.push_back(8'($urandom));
            cycle();
        end
        out_ready  = 1'b1;
        wr_pending = 1'b0;
        for (int i = 0; i < 40; i++) cycle();
        chk("rand_drained", out_valid, 1'b0);

`ifdef FIFO_DRAIN_FLUSH_EN
        // Flush discards queued bytes; the next byte written is the first one seen.
        out_ready = 1'b0;
        fq = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6};
        cnt_m = pop_count;
        flush_s = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_fifo_empty", fifo_pop, 1'b0);
        flush_s = 1'b0;
        out_ready = 1'b1;
        fq.push_back(8'h5A);
        cycle();
        chk("flush_first_byte", out_data, 8'h5A);
        chk("flush_first_valid", out_valid, 1'b1);
        cycle();
`endif

        // Counter wrap: 2^16-2 pops, then three more.
        do_reset();
        out_ready  = 1'b1;
        wr_pending = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            if (fq.size() < 2) fq.push_back(8'($urandom));
            cycle();
        end
        chk("wrap_pre", pop_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            if (fq.size() < 2) fq.push_back(8'($urandom));
            cycle();
        end
        chk("wrap_post", pop_count, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
